pc_unit: RTL and testbench

Parameterised successor to the combinational next-PC select. Owns the fetch PC register and the EPC register, plus a two-state exception-level FSM. It selects the next PC from sequential, branch, jr, j, exception vector and eret sources, honouring stall and exception priority. It sits at the F/D boundary: PC feeds instruction memory, and redirect inputs come from the D-stage decoder and comparator.

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_unit_npc_target_gen.sv | 31 +++
 rtl/pc_unit.sv | 120 ++++++++++++
 tb/tb_pc_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg
// Shared definitions for the fetch-PC unit and the decode controller that
// drives it: next-PC select encodings, reset/exception address defaults and
// the exception-level state type.
package pc_unit_pkg;

    // npc_sel encodings; unlisted codes decode as sequential
    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JR   = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_ERET = 3'b100;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

    typedef enum logic {
        EL_NORMAL = 1'b0,
        EL_EXL    = 1'b1
    } el_state_t;

endpackage

// File: rtl/pc_unit_npc_target_gen.sv
// npc_target_gen
// Purely combinational branch and jump target computation for the
// instruction currently in D. All arithmetic wraps modulo 2^ADDR_W.
//
// Ports:
//   pc_d     in   ADDR_W  PC of the instruction in D
//   imm16    in   16      branch word offset
//   index26  in   26      j/jal index field
//   br       out  ADDR_W  pc_d + 4 + sign_ext(imm16) * 4
//   j        out  ADDR_W  {(pc_d+4)[ADDR_W-1:28], index26, 2'b00}
module npc_target_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [15:0]       imm16,
    input  logic [25:0]       index26,
    output logic [ADDR_W-1:0] br,
    output logic [ADDR_W-1:0] j
);

    logic [ADDR_W-1:0] pc_d4;
    logic [ADDR_W-1:0] br_off;

    assign pc_d4  = pc_d + ADDR_W'(4);
    // word offset: sign-extend then scale by 4 in one concatenation
    assign br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign br     = pc_d4 + br_off;
    // ADDR_W >= 29 guarantees at least one region bit above the index
    assign j      = {pc_d4[ADDR_W-1:28], index26, 2'b00};

endmodule

// File: rtl/pc_unit.sv
// pc_unit
// Fetch PC register, EPC register and exception-level FSM. Chooses the next
// fetch PC from sequential, branch, jr, j, exception vector and eret sources.
//
// State | meaning
// ------+---------------------------------------------------------------
// NORMAL| exl=0; exc_req is taken (vector fetch, EPC captured)
// EXL   | exl=1; exc_req is masked; eret returns to EPC and NORMAL
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   stall             hold the PC (ignored by a taken exception)
//   npc_sel[2:0]      next-PC source select (see pc_unit_pkg)
//   cmp_true          branch condition from the D-stage comparator
//   pc_d, imm16,
//   index26           D-stage operands for branch / j targets
//   jr_target         forwarded rs value for jr
//   exc_req, exc_pc,
//   exc_bd            exception request, faulting PC, delay-slot flag
//   pc, epc, exl      registered fetch PC, return address, exception level
//   pc4               pc + 4
//   adel_f            fetch address misaligned
//   flush             exception or eret taken this cycle (combinational)
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        npc_sel,
    input  logic              cmp_true,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [15:0]       imm16,
    input  logic [25:0]       index26,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              exc_bd,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [ADDR_W-1:0] epc,
    output logic              exl,
    output logic              adel_f,
    output logic              flush
);

    localparam logic [ADDR_W-1:0] RST_PC  = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_VEC = EXC_VECTOR[ADDR_W-1:0];

    el_state_t         state_q;
    el_state_t         state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] epc_nxt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic              take_exc;
    logic              take_eret;

    npc_target_gen #(
        .ADDR_W (ADDR_W)
    ) u_tgt (
        .pc_d    (pc_d),
        .imm16   (imm16),
        .index26 (index26),
        .br      (br_tgt),
        .j       (j_tgt)
    );

    assign exl       = (state_q == EL_EXL);
    assign take_exc  = exc_req & ~exl;
    assign take_eret = (npc_sel == NPC_ERET) & ~stall & exl;
    // exc_req seen while reset is held must not look like a taken redirect
    assign flush     = (take_exc | take_eret) & ~reset;
    assign pc4       = pc + ADDR_W'(4);
    assign adel_f    = |pc[1:0];

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc;
        epc_nxt   = epc;

        case (state_q)
            EL_NORMAL: if (exc_req)   state_nxt = EL_EXL;
            EL_EXL:    if (take_eret) state_nxt = EL_NORMAL;
            default:                  state_nxt = EL_NORMAL;
        endcase

        if (take_exc) begin
            pc_nxt  = EXC_VEC;
            // return to the branch when the fault sat in its delay slot
            epc_nxt = exc_bd ? (exc_pc - ADDR_W'(4)) : exc_pc;
        end else if (take_eret) begin
            pc_nxt = epc;
        end else if (!stall) begin
            case (npc_sel)
                NPC_BR:  pc_nxt = cmp_true ? br_tgt : pc4;
                NPC_JR:  pc_nxt = jr_target;
                NPC_J:   pc_nxt = j_tgt;
                default: pc_nxt = pc4;   // seq, eret outside EXL, unused codes
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RST_PC;
            epc     <= '0;
            state_q <= EL_NORMAL;
        end else begin
            pc      <= pc_nxt;
            epc     <= epc_nxt;
            state_q <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_sel;
    logic        cmp_true;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] jr_target;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] pc, pc4, epc;
    logic        exl, adel_f, flush;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_exl;

    pc_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .cmp_true  (cmp_true),
        .pc_d      (pc_d),
        .imm16     (imm16),
        .index26   (index26),
        .jr_target (jr_target),
        .exc_req   (exc_req),
        .exc_pc    (exc_pc),
        .exc_bd    (exc_bd),
        .pc        (pc),
        .pc4       (pc4),
        .epc       (epc),
        .exl       (exl),
        .adel_f    (adel_f),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        stall     = 1'b0;
        npc_sel   = 3'b000;
        cmp_true  = 1'b0;
        pc_d      = 32'h0;
        imm16     = 16'h0;
        index26   = 26'h0;
        jr_target = 32'h0;
        exc_req   = 1'b0;
        exc_pc    = 32'h0;
        exc_bd    = 1'b0;
    endtask

    task automatic model_reset();
        m_pc  = 32'h0000_3000;
        m_epc = 32'h0;
        m_exl = 1'b0;
    endtask

    // One clock: check combinational outputs against the model, clock, then
    // check the registers. Called with inputs already driven after an edge.
    task automatic step(input string tag);
        logic        e_exc, e_eret;
        logic [31:0] n_pc, n_epc, br_t, j_t;
        logic        n_exl;
        #2;
        e_exc  = exc_req && !m_exl;
        e_eret = !e_exc && npc_sel == 3'd4 && !stall && m_exl;
        br_t   = pc_d + 32'd4 + 32'(int'(signed'(imm16)) * 4);
        j_t    = ((pc_d + 32'd4) & 32'hF000_0000) | (32'(index26) * 4);
        chk({tag, ".flush"},  {31'b0, flush},  {31'b0, e_exc | e_eret});
        chk({tag, ".pc4"},    pc4,             m_pc + 32'd4);
        chk({tag, ".adel_f"}, {31'b0, adel_f}, {31'b0, (m_pc % 4) != 0});
        n_pc = m_pc; n_epc = m_epc; n_exl = m_exl;
        if (e_exc) begin
            n_pc  = 32'h0000_4180;
            n_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
            n_exl = 1'b1;
        end else if (e_eret) begin
            n_pc  = m_epc;
            n_exl = 1'b0;
        end else if (!stall) begin
            if (npc_sel == 3'd1 && cmp_true) n_pc = br_t;
            else if (npc_sel == 3'd2)        n_pc = jr_target;
            else if (npc_sel == 3'd3)        n_pc = j_t;
            else                             n_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_epc = n_epc; m_exl = n_exl;
        chk({tag, ".pc"},  pc,            m_pc);
        chk({tag, ".epc"}, epc,           m_epc);
        chk({tag, ".exl"}, {31'b0, exl},  {31'b0, m_exl});
    endtask

    // Assert reset mid-cycle with an exception pending; reset must win at once.
    task automatic async_reset(input string tag);
        exc_req = 1'b1;
        exc_pc  = 32'h0000_3020;
        npc_sel = 3'd4;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".pc"},    pc,              m_pc);
        chk({tag, ".epc"},   epc,             32'h0);
        chk({tag, ".exl"},   {31'b0, exl},    32'h0);
        chk({tag, ".flush"}, {31'b0, flush},  32'h0);
        @(posedge clk);
        #1;
        chk({tag, ".hold"},  pc,              32'h0000_3000);
        idle();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset   = 1'b1;
        exc_req = 1'b1;               // ignored while in reset
        model_reset();
        #3;
        chk("rst.pc",    pc,             32'h0000_3000);
        chk("rst.epc",   epc,            32'h0);
        chk("rst.exl",   {31'b0, exl},   32'h0);
        chk("rst.flush", {31'b0, flush}, 32'h0);
        chk("rst.adel",  {31'b0, adel_f}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hold",  pc,             32'h0000_3000);
        idle();
        reset = 1'b0;

        // 1: sequential after reset
        step("seq1"); chk("seq1.val", pc, 32'h0000_3004);
        step("seq2"); chk("seq2.val", pc, 32'h0000_3008);

        // 2: branch taken / not taken, j
        pc_d = 32'h0000_3010; npc_sel = 3'd1; imm16 = 16'hFFFC; cmp_true = 1'b1;
        step("br_t"); chk("br_t.val", pc, 32'h0000_3004);
        cmp_true = 1'b0;
        step("br_nt"); chk("br_nt.val", pc, 32'h0000_3008);
        npc_sel = 3'd3; index26 = 26'h0000C40;
        step("j"); chk("j.val", pc, 32'h0000_3100);

        // 3: stalled jr, then released
        idle(); stall = 1'b1; npc_sel = 3'd2; jr_target = 32'h0000_3400;
        step("jr_stall"); chk("jr_stall.val", pc, 32'h0000_3100);
        stall = 1'b0;
        step("jr_go"); chk("jr_go.val", pc, 32'h0000_3400);

        // 4: exception ignores stall; second request masked in EXL
        idle(); exc_req = 1'b1; exc_pc = 32'h0000_3020; exc_bd = 1'b1; stall = 1'b1;
        step("exc"); chk("exc.epc_val", epc, 32'h0000_301C);
        stall = 1'b0; exc_pc = 32'h0000_3500; exc_bd = 1'b0;
        step("exc_mask"); chk("exc_mask.epc_val", epc, 32'h0000_301C);

        // 5: eret in EXL, then eret outside EXL behaves as seq
        idle(); npc_sel = 3'd4;
        step("eret"); chk("eret.val", pc, 32'h0000_301C);
        step("eret_n"); chk("eret_n.val", pc, 32'h0000_3020);

        // 6: misaligned jr, wrap, exception + eret same cycle
        idle(); npc_sel = 3'd2; jr_target = 32'h0000_3402;
        step("mis"); chk("mis.adel", {31'b0, adel_f}, 32'h1);
        jr_target = 32'hFFFF_FFFC;
        step("wrap_ld");
        idle();
        step("wrap"); chk("wrap.val", pc, 32'h0);
        npc_sel = 3'd4; exc_req = 1'b1; exc_pc = 32'h0000_3040;
        step("exc_eret"); chk("exc_eret.epc_val", epc, 32'h0000_3040);

        // reset while an exception/eret is pending
        async_reset("arst");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            npc_sel   = 3'($urandom_range(0, 7));
            cmp_true  = 1'($urandom);
            pc_d      = $urandom & 32'hFFFF_FFFC;
            imm16     = 16'($urandom);
            index26   = 26'($urandom);
            jr_target = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            exc_req   = ($urandom_range(0, 7) == 0);
            exc_pc    = $urandom;
            exc_bd    = 1'($urandom);
            if (i % 150 == 149) async_reset("rnd_rst");
            else                step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
